// File: rtl/branch_pkg.sv
// Shared types and constants for the BTB-based branch predictor.
package branch_pkg;

  typedef enum logic {
    PC = 1'b0,
    RD = 1'b1
  } addr_mode_t;

  typedef logic [1:0] ctr2_t;

  localparam ctr2_t CTR_WEAK_T = 2'b10;
  localparam ctr2_t CTR_RESET  = 2'b01;

  // Resettable part of an entry; tag and target live in separate unreset arrays.
  typedef struct packed {
    logic  valid;
    ctr2_t ctr;
  } btb_entry_t;

endpackage

// File: rtl/branch_predict_btb_if.sv
// Fetch lookup, execute resolve/train and status signals of the predictor.
interface branch_predict_btb_if #(
  parameter int WordSize = 32
);
  import branch_pkg::*;

  logic [WordSize-1:0] fetch_pc;
  logic                pred_taken;
  logic [WordSize-1:0] pred_npc;

  logic                ex_valid;
  logic [WordSize-1:0] ex_pc;
  addr_mode_t          ex_addr_mode;
  logic [WordSize-1:0] ex_imm;
  logic [WordSize-1:0] ex_rs1d;
  logic                ex_taken;
  logic                ex_pred_taken;
  logic [WordSize-1:0] ex_pred_npc;
  logic [WordSize-1:0] branch_addr;
  logic [WordSize-1:0] ex_npc;

  logic                btb_flush;
  logic                redirect_valid;
  logic [WordSize-1:0] redirect_pc;
  logic [WordSize-1:0] branch_count;
  logic [WordSize-1:0] mispredict_count;

  modport slave (
    input  fetch_pc, ex_valid, ex_pc, ex_addr_mode, ex_imm, ex_rs1d,
           ex_taken, ex_pred_taken, ex_pred_npc, btb_flush,
    output pred_taken, pred_npc, branch_addr, ex_npc,
           redirect_valid, redirect_pc, branch_count, mispredict_count
  );

  modport master (
    output fetch_pc, ex_valid, ex_pc, ex_addr_mode, ex_imm, ex_rs1d,
           ex_taken, ex_pred_taken, ex_pred_npc, btb_flush,
    input  pred_taken, pred_npc, branch_addr, ex_npc,
           redirect_valid, redirect_pc, branch_count, mispredict_count
  );

endinterface

// File: rtl/sat_ctr2.sv
// 2-bit saturating counter step: increment when inc_i, else decrement.
module sat_ctr2
  import branch_pkg::*;
(
  input  ctr2_t ctr_i,
  input  logic  inc_i,
  output ctr2_t ctr_o
);

  always_comb begin
    ctr_o = ctr_i;
    if (inc_i) begin
      if (ctr_i != 2'b11) ctr_o = ctr_i + 2'b01;
    end else begin
      if (ctr_i != 2'b00) ctr_o = ctr_i - 2'b01;
    end
  end

endmodule

// File: rtl/branch_predict_btb.sv
// Direct-mapped BTB with 2-bit direction counters: IF-stage lookup,
// EX-stage target resolve, mispredict redirect and table training.
module branch_predict_btb
  import branch_pkg::*;
#(
  parameter  int WordSize = 32,
  parameter  int Entries  = 16,
  localparam int IdxBits  = $clog2(Entries),
  localparam int TagBits  = WordSize - IdxBits - 2
) (
  input logic                  clk,
  input logic                  rstn,
  branch_predict_btb_if.slave  bus
);

  btb_entry_t          ent_q [Entries];
  btb_entry_t          ent_d [Entries];
  logic [TagBits-1:0]  tag_q [Entries];
  logic [TagBits-1:0]  tag_d [Entries];
  logic [WordSize-1:0] tgt_q [Entries];
  logic [WordSize-1:0] tgt_d [Entries];

  logic                redirect_valid_q, redirect_valid_d;
  logic [WordSize-1:0] redirect_pc_q, redirect_pc_d;
  logic [WordSize-1:0] branch_count_q, branch_count_d;
  logic [WordSize-1:0] mispredict_count_q, mispredict_count_d;

  // ---------------- fetch-side lookup ----------------
  logic [IdxBits-1:0] f_idx;
  logic [TagBits-1:0] f_tag;
  logic               f_hit;

  assign f_idx = bus.fetch_pc[IdxBits+1:2];
  assign f_tag = bus.fetch_pc[WordSize-1:IdxBits+2];
  assign f_hit = ent_q[f_idx].valid && (tag_q[f_idx] == f_tag);

  assign bus.pred_taken = f_hit && ent_q[f_idx].ctr[1];
  assign bus.pred_npc   = bus.pred_taken ? tgt_q[f_idx] : bus.fetch_pc + WordSize'(4);

  // ---------------- execute-side resolve ----------------
  logic [WordSize-1:0] pc_sum, rd_sum, branch_addr, ex_npc;
  logic                mispredict;

  assign pc_sum      = bus.ex_pc + bus.ex_imm;
  assign rd_sum      = bus.ex_rs1d + bus.ex_imm;
  assign branch_addr = (bus.ex_addr_mode == RD) ? {rd_sum[WordSize-1:1], 1'b0} : pc_sum;
  assign ex_npc      = bus.ex_taken ? branch_addr : bus.ex_pc + WordSize'(4);
  // Comparing full next-PCs catches both wrong direction and wrong target.
  assign mispredict  = bus.ex_valid && (bus.ex_pred_npc != ex_npc);

  assign bus.branch_addr = branch_addr;
  assign bus.ex_npc      = ex_npc;

  // ---------------- training ----------------
  logic [IdxBits-1:0] e_idx;
  logic [TagBits-1:0] e_tag;
  logic               e_hit;
  ctr2_t              ctr_upd;

  assign e_idx = bus.ex_pc[IdxBits+1:2];
  assign e_tag = bus.ex_pc[WordSize-1:IdxBits+2];
  assign e_hit = ent_q[e_idx].valid && (tag_q[e_idx] == e_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr_i (ent_q[e_idx].ctr),
    .inc_i (bus.ex_taken),
    .ctr_o (ctr_upd)
  );

  always_comb begin
    ent_d = ent_q;
    tag_d = tag_q;
    tgt_d = tgt_q;
    if (bus.ex_valid) begin
      if (bus.ex_taken) begin
        tgt_d[e_idx] = branch_addr;
        if (e_hit) begin
          ent_d[e_idx].ctr = ctr_upd;
        end else begin
          ent_d[e_idx].valid = 1'b1;
          ent_d[e_idx].ctr   = CTR_WEAK_T;
          tag_d[e_idx]       = e_tag;
        end
      end else if (e_hit) begin
        ent_d[e_idx].ctr = ctr_upd;
      end
    end
    // Flush wins over training: a same-cycle allocation is left invalid.
    if (bus.btb_flush) begin
      for (int i = 0; i < Entries; i++) ent_d[i].valid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < Entries; i++) begin
        ent_q[i].valid <= 1'b0;
        ent_q[i].ctr   <= CTR_RESET;
      end
    end else begin
      ent_q <= ent_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    tgt_q <= tgt_d;
  end

  // ---------------- redirect and statistics ----------------
  always_comb begin
    redirect_valid_d   = mispredict;
    redirect_pc_d      = mispredict ? ex_npc : redirect_pc_q;
    branch_count_d     = branch_count_q + (bus.ex_valid ? WordSize'(1) : WordSize'(0));
    mispredict_count_d = mispredict_count_q + (mispredict ? WordSize'(1) : WordSize'(0));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      redirect_valid_q   <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      redirect_valid_q   <= redirect_valid_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign bus.redirect_valid   = redirect_valid_q;
  assign bus.redirect_pc      = redirect_pc_q;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;

  // The carried direction bit is implied by ex_pred_npc; rd_sum[0] is masked off.
  logic unused_ok;
  assign unused_ok = ^{bus.ex_pred_taken, rd_sum[0]};

endmodule

// File: doc/branch_predict_btb.md
Name: branch_predict_btb

Overview:
Parametrised successor to the execute-stage branch address calculator. It combines a direct-mapped branch target buffer (BTB) with 2-bit saturating direction counters.
- Fetch side: a same-cycle prediction of the next PC.
- Execute side: computes the resolved target and next PC for PC-relative and register-relative branches, detects mispredictions, issues a registered redirect and trains the table.
- Placement: between IF (lookup) and EX (resolve/update).

Parameters:
WordSize, 32, data/address width in bits
Entries, 16, number of BTB entries; power of two, >= 2
IdxBits, $clog2(Entries), derived; not to be overridden
TagBits, WordSize-IdxBits-2, derived tag width

Ports:
clk  in  1  clock, rising edge
rstn  in  1  reset, asynchronous, active-low
fetch_pc  in  WordSize  PC being fetched
pred_taken  out  1  prediction: branch taken
pred_npc  out  WordSize  predicted next PC
ex_valid  in  1  a branch/jump resolves in EX this cycle
ex_pc  in  WordSize  PC of resolving branch
ex_addr_mode  in  1  PC = pc+imm, RD = rs1d+imm
ex_imm  in  WordSize  sign-extended immediate
ex_rs1d  in  WordSize  rs1 data
ex_taken  in  1  actual branch outcome
ex_pred_taken  in  1  prediction carried down the pipe with the branch
ex_pred_npc  in  WordSize  predicted next PC carried down the pipe
branch_addr  out  WordSize  resolved target (combinational)
ex_npc  out  WordSize  resolved next PC (combinational)
btb_flush  in  1  synchronous invalidate of all entries
redirect_valid  out  1  registered mispredict redirect
redirect_pc  out  WordSize  registered correct next PC
branch_count  out  WordSize  resolved branches since reset
mispredict_count  out  WordSize  mispredictions since reset

Behaviour:
Index and tag:
- idx = pc[IdxBits+1:2]
- tag = pc[WordSize-1:IdxBits+2]
- Entry fields: valid, tag, target, ctr[1:0].

Lookup (combinational, no bypass of same-cycle updates):
- hit = valid[idx] && tag match.
- pred_taken = hit && ctr[1].
- pred_npc = pred_taken ? target : fetch_pc+4.

Resolve (combinational):
- PC mode: branch_addr = ex_pc + ex_imm.
- RD mode: branch_addr = (ex_rs1d + ex_imm) with bit 0 cleared.
- All sums wrap modulo 2^WordSize.
- ex_npc = ex_taken ? branch_addr : ex_pc+4.
- mispredict = ex_valid && (ex_pred_npc != ex_npc). This covers wrong direction and wrong target.

Redirect (registered, 1-cycle latency):
- On each edge: redirect_valid <= mispredict; redirect_pc <= ex_npc when mispredict, else holds its value.
- redirect_valid is a single-cycle pulse per mispredict; back-to-back mispredicts give back-to-back pulses.

Training, on edge with ex_valid (table looked up at ex_pc):
- Taken and hit: ctr saturating increment (3 stays 3); target <= branch_addr.
- Taken and miss: allocate, overwriting any occupant. valid=1, tag, target=branch_addr, ctr=2'b10.
- Not taken and hit: ctr saturating decrement (0 stays 0); target unchanged.
- Not taken and miss: no change.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

btb_flush:
- Clears every valid bit at the edge; takes priority over a same-cycle training write.
- Counters and redirect are unaffected.

Counters:
- branch_count increments on ex_valid.
- mispredict_count increments on mispredict.
- Both wrap.

Reset (asserted):
- Immediately: all valid=0, all ctr=2'b01, redirect_valid=0, redirect_pc=0, branch_count=0, mispredict_count=0.
- Targets/tags need no reset.
- Reset mid-operation discards any pending redirect.

Decomposition:
- Package branch_pkg:
  - addr_mode_t enum {PC=0, RD=1}
  - 2-bit counter typedef
  - constants CTR_WEAK_T=2'b10 and CTR_RESET=2'b01
  - btb_entry_t struct
- Sub-module sat_ctr2: combinational 2-bit saturating inc/dec, instantiated once on the update path.

Test Plan:
1. Reset -> with fetch_pc=0x100: pred_taken=0, pred_npc=0x104; redirect_valid=0; both counters 0.
2. PC-mode branch at 0x100, imm=0x40, taken, pred_npc=0x104 -> branch_addr=0x140, ex_npc=0x140. Next cycle: redirect_valid=1, redirect_pc=0x140, mispredict_count=1. Then fetch_pc=0x100 gives pred_npc=0x140.
3. Same branch: two more taken (ctr 2->3->3), then three not-taken -> ctr 3->2->1->0. Prediction is taken while ctr>=2 and pred_npc=0x104 once ctr<=1; the first not-taken after saturation mispredicts.
4. RD mode, rs1d=0x2001, imm=0x10, taken -> branch_addr=0x2010 (bit 0 cleared). Correctly predicted (pred_npc=0x2010) -> redirect_valid stays 0; branch_count increments.
5. Aliasing: taken branches at 0x100 then at 0x100+4*Entries -> second evicts first. Lookup at 0x100 misses, predicting 0x104.
6. Fill 3 entries, assert btb_flush together with a taken update -> all lookups miss afterwards. Assert rstn low mid-redirect -> redirect_valid=0 immediately.
